// File: rtl/cpri_rx_lane_sched_pkg.sv
// Shared types and widths for the CPRI rx lane read scheduler.
// ST_FLUSH exists only when CPRI_RX_LANE_TMO_EN is defined.
package cpri_rx_pkg;

  localparam int CPRI_ADDR_W = 7;
  localparam int BLK_CNT_W   = 16;

`ifdef CPRI_RX_LANE_TMO_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ALL,
    ST_BURST,
    ST_GAP,
    ST_FLUSH
  } sched_st_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ALL,
    ST_BURST,
    ST_GAP
  } sched_st_t;
`endif

endpackage

// File: rtl/cpri_rx_lane_sched_if.sv
// Buffer-status / read-command bundle between the lane buffers, the scheduler and the unpack array.
// master = scheduler side, slave = buffer/unpack side.
interface cpri_rx_lane_sched_if #(
  parameter int LANE = 8
);
  import cpri_rx_pkg::*;

  logic [LANE-1:0]        i_lane_en;
  logic [LANE-1:0]        i_buf_vld;
  logic                   i_sink_rdy;
  logic                   i_err_clr;
  logic                   o_rd_en;
  logic [CPRI_ADDR_W-1:0] o_rd_addr;
  logic                   o_rd_last;
  logic                   o_blk_start;
  logic                   o_busy;
  logic [LANE-1:0]        o_lane_err;
  logic                   o_flush;
  logic [LANE-1:0]        o_flush_mask;
  logic [BLK_CNT_W-1:0]   o_blk_cnt;

  modport master (
    input  i_lane_en, i_buf_vld, i_sink_rdy, i_err_clr,
    output o_rd_en, o_rd_addr, o_rd_last, o_blk_start, o_busy,
           o_lane_err, o_flush, o_flush_mask, o_blk_cnt
  );

  modport slave (
    output i_lane_en, i_buf_vld, i_sink_rdy, i_err_clr,
    input  o_rd_en, o_rd_addr, o_rd_last, o_blk_start, o_busy,
           o_lane_err, o_flush, o_flush_mask, o_blk_cnt
  );

endinterface

// File: rtl/cpri_rx_lane_sched_tmo_cnt.sv
// WAIT_ALL timeout counter: clear has priority, counts while enabled, holds once expired.
// o_expire is combinational from the count; used only when CPRI_RX_LANE_TMO_EN is defined.
module cpri_lane_tmo_cnt #(
  parameter int TMO_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int TMO_W = $clog2(TMO_CYC);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && !o_expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = (cnt == TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/cpri_rx_lane_sched.sv
// Lock-step burst reader over all enabled lane buffers: rd_en follows i_sink_rdy with zero latency, GAP_CYC idle
// cycles after each block. Optional WAIT_ALL timeout + flush under CPRI_RX_LANE_TMO_EN.
module cpri_rx_lane_sched
  import cpri_rx_pkg::*;
#(
  parameter int LANE      = 8,
  parameter int BLK_BEATS = 96,
  parameter int GAP_CYC   = 4,
  parameter int TMO_CYC   = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  cpri_rx_lane_sched_if.master bus
);
  localparam int                     GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CPRI_ADDR_W-1:0] ADDR_LAST = CPRI_ADDR_W'(BLK_BEATS - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(GAP_CYC - 1);

  if (BLK_BEATS < 2 || BLK_BEATS > 128 || GAP_CYC < 1 || TMO_CYC < 2) begin : g_cfg_chk
    $error("cpri_rx_lane_sched: parameter out of range");
  end

  sched_st_t              st, st_nxt;
  logic [LANE-1:0]        msk;
  logic [LANE-1:0]        lane_err;
  logic [LANE-1:0]        err_set;
  logic [LANE-1:0]        flush_mask;
  logic [CPRI_ADDR_W-1:0] addr;
  logic [GAP_W-1:0]       gap_cnt;
  logic [BLK_CNT_W-1:0]   blk_cnt;
  logic                   rd_en;
  logic                   flush;
  logic                   idle_go;
  logic                   wait_go;
  logic                   last_beat;

  // IDLE decides on the live enable mask; later states use the copy latched on leaving IDLE.
  assign idle_go   = ((bus.i_buf_vld & bus.i_lane_en) == bus.i_lane_en) && bus.i_sink_rdy;
  assign wait_go   = ((bus.i_buf_vld & msk) == msk) && bus.i_sink_rdy;
  assign last_beat = (addr == ADDR_LAST);

`ifdef CPRI_RX_LANE_TMO_EN
  logic tmo_exp;

  cpri_lane_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (st == ST_IDLE),
    .i_en     (st == ST_WAIT_ALL),
    .o_expire (tmo_exp)
  );
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) st <= ST_IDLE;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE: begin
        if (|bus.i_lane_en) begin
          if (idle_go)                              st_nxt = ST_BURST;
          else if (|(bus.i_buf_vld & bus.i_lane_en)) st_nxt = ST_WAIT_ALL;
        end
      end
      ST_WAIT_ALL: begin
        if (wait_go) st_nxt = ST_BURST;
`ifdef CPRI_RX_LANE_TMO_EN
        else if (tmo_exp) st_nxt = ST_FLUSH;
`endif
      end
      ST_BURST: if (rd_en && last_beat)     st_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST)    st_nxt = ST_IDLE;
`ifdef CPRI_RX_LANE_TMO_EN
      ST_FLUSH: st_nxt = ST_GAP;
`endif
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    flush      = 1'b0;
    flush_mask = '0;
    err_set    = '0;
    case (st)
      ST_BURST: begin
        rd_en   = bus.i_sink_rdy;
        err_set = msk & ~bus.i_buf_vld;
      end
`ifdef CPRI_RX_LANE_TMO_EN
      ST_FLUSH: begin
        flush      = 1'b1;
        flush_mask = bus.i_buf_vld & msk;
        err_set    = msk & ~bus.i_buf_vld;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      msk      <= '0;
      addr     <= '0;
      gap_cnt  <= '0;
      blk_cnt  <= '0;
      lane_err <= '0;
    end else begin
      if (st == ST_IDLE && |bus.i_lane_en) msk <= bus.i_lane_en;
      if (rd_en) addr <= last_beat ? '0 : addr + 1'b1;
      if (rd_en && last_beat) blk_cnt <= blk_cnt + 1'b1;
      gap_cnt  <= (st == ST_GAP && gap_cnt != GAP_LAST) ? gap_cnt + 1'b1 : '0;
      // A new set in the same cycle as a clear survives.
      lane_err <= (lane_err & ~{LANE{bus.i_err_clr}}) | err_set;
    end
  end

  assign bus.o_rd_en      = rd_en;
  assign bus.o_rd_addr    = addr;
  assign bus.o_rd_last    = rd_en & last_beat;
  assign bus.o_blk_start  = rd_en & (addr == '0);
  assign bus.o_busy       = (st != ST_IDLE);
  assign bus.o_lane_err   = lane_err;
  assign bus.o_flush      = flush;
  assign bus.o_flush_mask = flush_mask;
  assign bus.o_blk_cnt    = blk_cnt;

endmodule

// File: tb/tb_cpri_rx_lane_sched.sv
// Randomized bench for cpri_rx_lane_sched: phase-level reference model per block plus a beat scoreboard.
`timescale 1ns/1ps
module tb_cpri_rx_lane_sched;
  import cpri_rx_pkg::*;

  localparam int LANE      = 8;
  localparam int BLK_BEATS = 96;
  localparam int GAP_CYC   = 4;
  localparam int TMO_CYC   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpri_rx_lane_sched_if #(.LANE(LANE)) bus ();

  cpri_rx_lane_sched #(
    .LANE(LANE), .BLK_BEATS(BLK_BEATS), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic        last;
    logic        start;
    logic [15:0] cnt;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_err  = '0;
  logic [15:0] exp_cnt  = '0;
  logic [6:0]  exp_addr = '0;
  logic        exp_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected beat.
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst) begin
      if (bus.o_rd_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: rd_en=1 addr=%0d, expected no beat", bus.o_rd_addr);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr",  32'(bus.o_rd_addr),   32'(e.addr));
          check("beat_last",  32'(bus.o_rd_last),   32'(e.last));
          check("beat_start", 32'(bus.o_blk_start), 32'(e.start));
          check("beat_cnt",   32'(bus.o_blk_cnt),   32'(e.cnt));
        end
      end else begin
        check("no_beat_flags", 32'({bus.o_rd_last, bus.o_blk_start}), 32'(0));
      end
    end
  end

  // One clock cycle: drive inputs after the edge, then compare against the model state.
  task automatic cyc(input logic [7:0] en, input logic [7:0] vld, input logic rdy, input logic clr,
                     input logic exp_rd, input logic exp_fl, input logic [7:0] exp_fm);
    @(posedge clk);
    #1;
    bus.i_lane_en  = en;
    bus.i_buf_vld  = vld;
    bus.i_sink_rdy = rdy;
    bus.i_err_clr  = clr;
    #2;
    check("rd_en",      32'(bus.o_rd_en),      32'(exp_rd));
    check("rd_addr",    32'(bus.o_rd_addr),    32'(exp_addr));
    check("busy",       32'(bus.o_busy),       32'(exp_busy));
    check("lane_err",   32'(bus.o_lane_err),   32'(exp_err));
    check("blk_cnt",    32'(bus.o_blk_cnt),    32'(exp_cnt));
    check("flush",      32'(bus.o_flush),      32'(exp_fl));
    check("flush_mask", 32'(bus.o_flush_mask), 32'(exp_fm));
  endtask

  task automatic gap_phase(input logic [7:0] en);
    for (int g = 0; g < GAP_CYC; g++) cyc(en, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 8'h00);
    exp_busy = 1'b0;
  endtask

  task automatic idle_cyc(input logic clr);
    cyc(8'hFF, 8'h00, 1'b1, clr, 1'b0, 1'b0, 8'h00);
    if (clr) exp_err = 8'h00;
  endtask

  // One block: wait for all enabled lanes, burst BLK_BEATS accepted beats, then the gap.
  task automatic run_block(input logic [7:0] en, input logic [7:0] first_vld, input int late,
                           input int pre_pct, input int bst_pct, input int stall_at, input int stall_len,
                           input int drop_lane, input int drop_beat, input int clr_beat, input int rst_beat);
    logic [7:0] vld;
    logic       rdy;
    logic       clr;
    int         c;
    int         beats;
    int         stalled;
    bit         clr_done;
    beat_t      e;

    c = 0;
    forever begin
      vld = (((c >= late) ? en : first_vld) & en) | (8'($urandom) & ~en);
      rdy = ($urandom_range(0, 99) < pre_pct);
      cyc(en, vld, rdy, 1'b0, 1'b0, 1'b0, 8'h00);
      if (((vld & en) == en) && rdy) break;
      if ((vld & en) != 8'h00) exp_busy = 1'b1;
      c++;
      if (c > 3000) begin
        checks++;
        errors++;
        $display("FAIL burst_start_timeout: waited %0d cycles, limit 3000", c);
        return;
      end
    end
    exp_busy = 1'b1;

    for (int b = 0; b < BLK_BEATS; b++) begin
      e.addr  = 7'(b);
      e.last  = (b == BLK_BEATS - 1);
      e.start = (b == 0);
      e.cnt   = exp_cnt;
      exp_q.push_back(e);
    end

    beats    = 0;
    stalled  = 0;
    clr_done = 1'b0;
    while (beats < BLK_BEATS) begin
      if (beats == rst_beat) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("rst_rd_en",   32'(bus.o_rd_en),     32'(0));
        check("rst_busy",    32'(bus.o_busy),      32'(0));
        check("rst_addr",    32'(bus.o_rd_addr),   32'(0));
        check("rst_lane_err", 32'(bus.o_lane_err), 32'(0));
        check("rst_blk_cnt", 32'(bus.o_blk_cnt),   32'(0));
        check("rst_start",   32'(bus.o_blk_start), 32'(0));
        exp_q.delete();
        exp_err  = '0;
        exp_cnt  = '0;
        exp_addr = '0;
        exp_busy = 1'b0;
        bus.i_buf_vld = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (beats == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = ($urandom_range(0, 99) < bst_pct);
      end
      vld = en | (8'($urandom) & ~en);
      if (drop_lane >= 0 && beats >= drop_beat) vld[drop_lane] = 1'b0;
      clr = 1'b0;
      if (!clr_done && beats == clr_beat) begin
        clr      = 1'b1;
        clr_done = 1'b1;
      end
      cyc(en, vld, rdy, clr, rdy, 1'b0, 8'h00);
      exp_err = (exp_err & ~{8{clr}}) | (en & ~vld);
      if (rdy) begin
        beats++;
        exp_addr = 7'(beats % BLK_BEATS);
      end
    end
    exp_cnt++;
    gap_phase(en);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $fatal(1);
  end

  initial begin : main
    bus.i_lane_en  = 8'h00;
    bus.i_buf_vld  = 8'h00;
    bus.i_sink_rdy = 1'b1;
    bus.i_err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("reset_rd_en",    32'(bus.o_rd_en),      32'(0));
    check("reset_busy",     32'(bus.o_busy),       32'(0));
    check("reset_blk_cnt",  32'(bus.o_blk_cnt),    32'(0));
    check("reset_lane_err", 32'(bus.o_lane_err),   32'(0));
    check("reset_flush",    32'(bus.o_flush),      32'(0));
    check("reset_fmask",    32'(bus.o_flush_mask), 32'(0));
    #1;
    rst = 1'b0;
    idle_cyc(1'b0);

    // all lanes ready immediately
    run_block(8'hFF, 8'hFF, 0, 100, 100, -1, 0, -1, 0, -1, -1);
    // lanes 0-2 ready, lane 3 late, upper lanes are noise
    run_block(8'h0F, 8'h07, 10, 100, 100, -1, 0, -1, 0, -1, -1);
    // 5-cycle sink stall at beat 20
    run_block(8'hFF, 8'hFF, 0, 100, 100, 20, 5, -1, 0, -1, -1);
    // lane 5 drops at beat 40, then clear, then clear coincident with a new drop
    run_block(8'hFF, 8'hFF, 0, 100, 100, -1, 0, 5, 40, -1, -1);
    idle_cyc(1'b1);
    idle_cyc(1'b0);
    run_block(8'hFF, 8'hFF, 0, 100, 100, -1, 0, 5, 30, 30, -1);
    idle_cyc(1'b1);
    // lane 7 absent for a long time
    run_block(8'hFF, 8'h7F, 300, 100, 100, -1, 0, -1, 0, -1, -1);

`ifdef CPRI_RX_LANE_TMO_EN
    cyc(8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    exp_busy = 1'b1;
    for (int k = 0; k < TMO_CYC; k++) cyc(8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F);
    exp_err = exp_err | 8'h80;
    gap_phase(8'hFF);
    idle_cyc(1'b1);
`endif

    for (int r = 0; r < 8; r++) begin
      run_block(8'($urandom_range(1, 255)), 8'($urandom), int'($urandom_range(0, 12)), 70, 75,
                int'($urandom_range(0, 95)), int'($urandom_range(0, 6)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, int'($urandom_range(0, 95)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 95)) : -1, -1);
    end

    // reset in the middle of a block, then a clean block
    run_block(8'hFF, 8'hFF, 0, 100, 100, -1, 0, 2, 10, -1, 50);
    idle_cyc(1'b0);
    run_block(8'hFF, 8'hFF, 0, 100, 100, -1, 0, -1, 0, -1, -1);
    idle_cyc(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
